// File: rtl/fc_result_collect.sv
// Collects class-major partial sums for 10 classes, saturates each class total to 16 bits
// and emits one packed 160-bit result write per frame. Optional macro RESULT_RELU_EN clamps negative lanes to 0.
module fc_result_collect (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   cfg_num_partials,
  input  logic         in_valid,
  input  logic [15:0]  in_data,
  output logic         in_ready,
  output logic [159:0] write_result_data,
  output logic         write_result_signal,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [7:0]          n_r;
  logic [3:0]          class_cnt_r;
  logic [7:0]          part_cnt_r;
  logic signed [23:0]  acc_r;
  logic [9:0][15:0]    lanes_r;
  logic [9:0][15:0]    lanes_next_s;
  logic                accept_s;
  logic                last_beat_s;
  logic signed [23:0]  ext_s;
  logic signed [23:0]  sum_s;

  function automatic logic [15:0] sat_lane(input logic signed [23:0] v);
    logic [15:0] s;
    if (v > 24'sh007FFF) begin
      s = 16'h7FFF;
    end else if (v < 24'shFF8000) begin
      s = 16'h8000;
    end else begin
      s = v[15:0];
    end
`ifdef RESULT_RELU_EN
    s = s[15] ? 16'h0000 : s;
`endif
    return s;
  endfunction

  assign accept_s    = (state_r == ACCUM) && in_valid && in_ready;
  assign last_beat_s = (part_cnt_r == (n_r - 8'd1));
  assign ext_s       = {{8{in_data[15]}}, in_data};
  assign sum_s       = (part_cnt_r == 8'd0) ? ext_s : (acc_r + ext_s);

  // Next-state and next-lane decode.
  always_comb begin
    state_next_s = state_r;
    lanes_next_s = lanes_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ACCUM;
          lanes_next_s = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && last_beat_s) begin
          lanes_next_s[class_cnt_r] = sat_lane(sum_s);
          if (class_cnt_r == 4'd9) begin
            state_next_s = WRITE;
          end else begin
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      WRITE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, counters, accumulator, lanes and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= IDLE;
      n_r                 <= 8'd0;
      class_cnt_r         <= 4'd0;
      part_cnt_r          <= 8'd0;
      acc_r               <= 24'sd0;
      lanes_r             <= '0;
      in_ready            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      write_result_signal <= 1'b0;
      write_result_data   <= 160'd0;
    end else begin
      state_r             <= state_next_s;
      lanes_r             <= lanes_next_s;
      in_ready            <= (state_next_s == ACCUM);
      busy                <= (state_next_s == ACCUM) || (state_next_s == WRITE);
      done                <= (state_next_s == WRITE);
      write_result_signal <= (state_next_s == WRITE);
      // Data is captured together with the strobe so it includes the final lane.
      if (state_next_s == WRITE) begin
        write_result_data <= lanes_next_s;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            n_r         <= (cfg_num_partials == 8'd0) ? 8'd1 : cfg_num_partials;
            class_cnt_r <= 4'd0;
            part_cnt_r  <= 8'd0;
            acc_r       <= 24'sd0;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_r <= sum_s;
            if (last_beat_s) begin
              part_cnt_r  <= 8'd0;
              class_cnt_r <= class_cnt_r + 4'd1;
            end else begin
              part_cnt_r <= part_cnt_r + 8'd1;
            end
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

endmodule

// File: doc/fc_result_collect.md
FC_RESULT_COLLECT -- requirements
Module: fc_result_collect

Interface
REQ-001 The block SHALL have no parameters; the class count is fixed at 10 and the lane width at 16 bits.
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a frame; SHALL be sampled only in IDLE.
REQ-005 cfg_num_partials  input  8  partial sums per class, latched on an accepted start; the value 0 SHALL be treated as 1.
REQ-006 in_valid  input  1  a partial sum is present on in_data.
REQ-007 in_data  input  16  signed two's-complement partial sum.
REQ-008 in_ready  output  1  the block can accept in_data.
REQ-009 write_result_data  output  160  packed class scores; class k SHALL occupy bits [16k+15:16k].
REQ-010 write_result_signal  output  1  one-cycle write strobe to the result memory.
REQ-011 busy  output  1  high in ACCUM and WRITE.
REQ-012 done  output  1  one-cycle pulse, coincident with write_result_signal.

Function
REQ-013 The block SHALL implement three states: IDLE, ACCUM and WRITE.
REQ-014 In IDLE, start=1 SHALL latch cfg_num_partials (as N), clear the class and partial counters, clear all lanes and move to ACCUM on the next cycle.
REQ-015 A beat SHALL be accepted only when in_valid=1, in_ready=1 and the state is ACCUM.
REQ-016 in_ready SHALL be 1 only in ACCUM.
REQ-017 Partial sums SHALL arrive class-major: N beats for class 0, then N beats for class 1, and so on through class 9.
REQ-018 On the first beat of a class, the 24-bit signed accumulator SHALL load sign-extended in_data; on each later beat it SHALL add sign-extended in_data.
REQ-019 The accumulator SHALL never overflow, because 255 x 2^15 < 2^23.
REQ-020 On the N-th beat of a class, the final sum, including that beat, SHALL be saturated to [-32768, 32767] and written into lane[class_cnt].
REQ-021 After the N-th beat of a class, the partial counter SHALL wrap to 0 and the class counter SHALL increment.
REQ-022 When the N-th beat of class 9 is accepted, the state SHALL move to WRITE.
REQ-023 In WRITE, write_result_signal and done SHALL be 1 for exactly one cycle, write_result_data SHALL equal the packed lanes, and the state SHALL return to IDLE.
REQ-024 Latency: write_result_signal SHALL rise on the cycle after the final beat is accepted.
REQ-025 write_result_data SHALL hold the last packed value outside WRITE; consumers SHALL qualify it with write_result_signal.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT restart the frame.
REQ-027 in_valid=1 outside ACCUM SHALL be ignored, with no counter or lane change.
REQ-028 Gaps in in_valid during ACCUM SHALL stall the counters, with no timeout.

Reset
REQ-029 On rst=1 the block SHALL set state IDLE, zero both counters, the accumulator, all lanes and N, and drive in_ready=0, busy=0, done=0, write_result_signal=0 and write_result_data=0.
REQ-030 rst=1 mid-frame SHALL abort the frame with no write_result_signal pulse; rst SHALL take priority over start and in_valid.

Configuration
REQ-031 With macro RESULT_RELU_EN defined, a saturated lane value below 0 SHALL be stored as 0.
REQ-032 Without RESULT_RELU_EN, saturated signed values SHALL be stored unchanged.
REQ-033 RESULT_RELU_EN SHALL NOT alter timing or handshake behaviour.

Verification
REQ-034 Case: N=1, in_data=k+1 for class k, with no gaps -> the pulse arrives 1 cycle after the 10th beat with data {16'd10,...,16'd2,16'd1}, and done is coincident.
REQ-035 Case: N=4, with class 3 beats 16'h7FFF x4 and all others 0 -> lane3=16'h7FFF (saturated) and all other lanes 0.
REQ-036 Case: N=2, with class 5 beats -20000 and -20000 -> lane5=16'h8000 without RESULT_RELU_EN, and lane5=0 with it.
REQ-037 Case: random in_valid gaps, N=3, and start pulsed during ACCUM -> the result matches the gap-free run, the start is ignored, and exactly one pulse occurs.
REQ-038 Case: rst asserted after the 15th beat, then a new frame with N=0 -> no pulse for the aborted frame; the new frame behaves as N=1 and its lanes exclude the aborted data.
REQ-039 Case: cfg_num_partials=0 -> 10 beats produce one pulse.
REQ-040 Case: in_valid held at 1 during IDLE or WRITE -> no acceptance occurs.
